// File: rtl/mempipe_ctl_pkg.sv
// mempipe_ctl_pkg: shared memory-pipe types and sizing constants.
//   t_mempipe_arb    : request packet carried down mm1..mm5
//   t_nuke_pkt       : pipeline nuke broadcast (only .valid used by the pipe)
//   t_mempipe_action : {complete, recycle} verdict reported at mm5
package mempipe_ctl_pkg;

    localparam int MEMPIPE_NUM_REQS   = 2;
    localparam int MEMPIPE_NUM_STAGES = 5;

    typedef struct packed {
        logic [1:0]  src;
        logic        is_store;
        logic [11:0] index;
        logic [7:0]  id;
    } t_mempipe_arb;

    typedef struct packed {
        logic       valid;
        logic [5:0] rob_id;
    } t_nuke_pkt;

    typedef struct packed {
        logic complete;
        logic recycle;
    } t_mempipe_action;

endpackage

// File: rtl/mempipe_ctl_rr_arb.sv
// mempipe_rr_arb: N-way round-robin one-hot select with rotating priority pointer.
//   clk, reset : clock, async active-high reset (pointer -> 0)
//   i_req      : per-requestor request
//   i_block    : suppress every grant this cycle (pointer holds)
//   o_gnt      : one-hot or zero grant
//   o_ptr      : current highest-priority requestor
module mempipe_rr_arb #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_req,
    input  logic          i_block,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nxt;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Scan from r_ptr upward (wrapping); first requester wins and the pointer
    // moves just past it so it becomes lowest priority next time.
    always_comb begin
        o_gnt   = '0;
        w_nxt   = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % N);
            if (!w_found && !i_block && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_nxt        = PW'((int'(w_idx) + 1) % N);
                w_found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ptr <= '0;
        else       r_ptr <= w_nxt;
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/mempipe_ctl.sv
// mempipe_ctl: memory-pipe responder; arbitrates mm0 requests and carries the
// granted packet down a stall-free 5-stage pipe, reporting the verdict at mm5.
//   clk, reset        : clock, async active-high reset
//   nuke_rb1          : pipeline nuke (.valid kills all in-flight ops)
//   req_mm0/req_pkt   : per-requestor request and packet (0 = loadq, 1 = storeq)
//   gnt_mm0           : one-hot grant, same cycle as the request
//   arb_block_mm0     : suppress all grants this cycle
//   lookup_*_mm2      : tag-lookup view of the op in mm2
//   dc_hit_mm3        : tag hit for the op in mm3
//   pipe_*_mm5        : completion broadcast of the op in mm5
module mempipe_ctl
    import mempipe_ctl_pkg::*;
#(
    parameter int NUM_REQS = MEMPIPE_NUM_REQS
) (
    input  logic                clk,
    input  logic                reset,
    input  t_nuke_pkt           nuke_rb1,
    input  logic [NUM_REQS-1:0] req_mm0,
    input  t_mempipe_arb        req_pkt_mm0 [NUM_REQS],
    output logic [NUM_REQS-1:0] gnt_mm0,
    input  logic                arb_block_mm0,
    output logic                lookup_valid_mm2,
    output t_mempipe_arb        lookup_pkt_mm2,
    input  logic                dc_hit_mm3,
    output logic                pipe_valid_mm5,
    output t_mempipe_arb        pipe_req_pkt_mm5,
    output t_mempipe_action     pipe_action_mm5
);

    localparam int NS = MEMPIPE_NUM_STAGES;
    localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NS:1]   r_valid;
    t_mempipe_arb  r_pkt [1:NS];
    logic          r_hit_mm4;
    logic          r_hit_mm5;
    t_mempipe_arb  w_gnt_pkt;
    logic          w_block;
    logic [PW-1:0] w_rr_ptr;
    logic          w_unused;

    // Reset is folded in so gnt_mm0 reads zero while reset is held.
    assign w_block = arb_block_mm0 | nuke_rb1.valid | reset;

    mempipe_rr_arb #(.N(NUM_REQS), .PW(PW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (req_mm0),
        .i_block (w_block),
        .o_gnt   (gnt_mm0),
        .o_ptr   (w_rr_ptr)
    );

    always_comb begin
        w_gnt_pkt = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (gnt_mm0[k]) w_gnt_pkt = req_pkt_mm0[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= '0;
            r_pkt     <= '{default: '0};
            r_hit_mm4 <= 1'b0;
            r_hit_mm5 <= 1'b0;
        end else begin
            r_valid  <= nuke_rb1.valid ? '0 : {r_valid[NS-1:1], |gnt_mm0};
            r_pkt[1] <= w_gnt_pkt;
            for (int s = 2; s <= NS; s++) r_pkt[s] <= r_pkt[s-1];
            if (r_valid[3]) r_hit_mm4 <= dc_hit_mm3;
            r_hit_mm5 <= r_hit_mm4;
        end
    end

    assign lookup_valid_mm2 = r_valid[2] & ~nuke_rb1.valid;
    assign lookup_pkt_mm2   = r_pkt[2];
    assign pipe_valid_mm5   = r_valid[NS] & ~nuke_rb1.valid;
    assign pipe_req_pkt_mm5 = r_pkt[NS];
    assign pipe_action_mm5  = '{complete: r_hit_mm5, recycle: ~r_hit_mm5};

    assign w_unused = ^{nuke_rb1.rob_id, w_rr_ptr};

endmodule

// File: tb/tb_mempipe_ctl.sv
// tb_mempipe_ctl: randomized + directed bench for mempipe_ctl against a cycle-history model.
module tb_mempipe_ctl;
    import mempipe_ctl_pkg::*;

    localparam int N    = 2;
    localparam int MAXC = 2048;

    logic            clk;
    logic            reset;
    t_nuke_pkt       nuke_rb1;
    logic [N-1:0]    req_mm0;
    t_mempipe_arb    req_pkt_mm0 [N];
    logic [N-1:0]    gnt_mm0;
    logic            arb_block_mm0;
    logic            lookup_valid_mm2;
    t_mempipe_arb    lookup_pkt_mm2;
    logic            dc_hit_mm3;
    logic            pipe_valid_mm5;
    t_mempipe_arb    pipe_req_pkt_mm5;
    t_mempipe_action pipe_action_mm5;

    mempipe_ctl #(.NUM_REQS(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .nuke_rb1         (nuke_rb1),
        .req_mm0          (req_mm0),
        .req_pkt_mm0      (req_pkt_mm0),
        .gnt_mm0          (gnt_mm0),
        .arb_block_mm0    (arb_block_mm0),
        .lookup_valid_mm2 (lookup_valid_mm2),
        .lookup_pkt_mm2   (lookup_pkt_mm2),
        .dc_hit_mm3       (dc_hit_mm3),
        .pipe_valid_mm5   (pipe_valid_mm5),
        .pipe_req_pkt_mm5 (pipe_req_pkt_mm5),
        .pipe_action_mm5  (pipe_action_mm5)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_ptr = 0;

    // History indexed by cycle: what was granted, whether the pipe was killed, hit input.
    bit           m_gv   [MAXC];
    t_mempipe_arb m_gp   [MAXC];
    bit           m_kill [MAXC];
    bit           m_hit  [MAXC];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // An op granted in cycle t is visible d cycles later unless a nuke/reset hit it in between.
    function automatic bit alive(input int t, input int upto);
        if (t < 0 || !m_gv[t]) return 1'b0;
        for (int c = t + 1; c <= upto; c++) if (m_kill[c]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin : cmp
        logic [N-1:0] eg;
        t_mempipe_arb ep;
        int gk;
        int t;
        bit a;
        eg = '0;
        ep = '0;
        gk = -1;
        if (!(reset || arb_block_mm0 || nuke_rb1.valid))
            for (int i = 0; i < N; i++)
                if (gk < 0 && req_mm0[(m_ptr + i) % N]) gk = (m_ptr + i) % N;
        if (gk >= 0) begin
            eg[gk] = 1'b1;
            ep = req_pkt_mm0[gk];
        end
        m_ptr = reset ? 0 : (gk >= 0 ? (gk + 1) % N : m_ptr);
        if (cyc < MAXC) begin
            m_gv[cyc]   = (gk >= 0);
            m_gp[cyc]   = ep;
            m_kill[cyc] = reset || nuke_rb1.valid;
            m_hit[cyc]  = dc_hit_mm3;
            chk("gnt", gnt_mm0, eg);
            t = cyc - 2;
            a = alive(t, cyc);
            chk("lookup_valid", lookup_valid_mm2, a);
            if (a) chk("lookup_pkt", lookup_pkt_mm2, m_gp[t]);
            t = cyc - 5;
            a = alive(t, cyc);
            chk("pipe_valid", pipe_valid_mm5, a);
            if (a) begin
                chk("pipe_pkt", pipe_req_pkt_mm5, m_gp[t]);
                chk("pipe_action", pipe_action_mm5, {m_hit[t+3], !m_hit[t+3]});
            end
        end
    end

    task automatic drive(input logic rs, input logic [N-1:0] rq, input logic blk,
                         input logic nk, input logic hit);
        reset           = rs;
        req_mm0         = rq;
        arb_block_mm0   = blk;
        nuke_rb1.valid  = nk;
        nuke_rb1.rob_id = 6'($urandom);
        dc_hit_mm3      = hit;
        for (int k = 0; k < N; k++)
            req_pkt_mm0[k] = '{src: 2'(k), is_store: (k == 1), index: 12'($urandom), id: 8'($urandom)};
    endtask

    // Advance to the next cycle, drive it, and stop at its negedge for checks.
    task automatic go(input logic rs, input logic [N-1:0] rq, input logic blk,
                      input logic nk, input logic hit);
        @(posedge clk);
        #1;
        cyc++;
        drive(rs, rq, blk, nk, hit);
        @(negedge clk);
    endtask

    t_mempipe_arb p;
    t_mempipe_arb p3 [4];

    initial begin
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
        go(1'b1, 2'b00, 0, 0, 0);
        chk("rst_pipe_valid", pipe_valid_mm5, 1'b0);
        chk("rst_gnt", gnt_mm0, 2'b00);
        go(0, 2'b00, 0, 0, 0);
        go(0, 2'b00, 0, 0, 0);

        // single storeq request, hit at T+3
        go(0, 2'b10, 0, 0, 0);
        chk("t2_gnt", gnt_mm0, 2'b10);
        p = req_pkt_mm0[1];
        go(0, 2'b00, 0, 0, 0);
        go(0, 2'b00, 0, 0, 0);
        chk("t2_lookup_valid", lookup_valid_mm2, 1'b1);
        chk("t2_lookup_pkt", lookup_pkt_mm2, p);
        go(0, 2'b00, 0, 0, 1);
        go(0, 2'b00, 0, 0, 0);
        go(0, 2'b00, 0, 0, 0);
        chk("t2_pipe_valid", pipe_valid_mm5, 1'b1);
        chk("t2_pipe_pkt", pipe_req_pkt_mm5, p);
        chk("t2_action", pipe_action_mm5, 2'b10);

        // both request continuously, pointer starts at 0
        for (int i = 0; i < 4; i++) begin
            go(0, 2'b11, 0, 0, 1);
            chk("t3_gnt", gnt_mm0, (i % 2 == 0) ? 2'b01 : 2'b10);
            p3[i] = req_pkt_mm0[i % 2];
        end
        go(0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            go(0, 2'b00, 0, 0, 0);
            chk("t3_pipe_valid", pipe_valid_mm5, 1'b1);
            chk("t3_pipe_src", pipe_req_pkt_mm5.src, 2'(i % 2));
            chk("t3_pipe_pkt", pipe_req_pkt_mm5, p3[i]);
        end

        // back-to-back ops, hits 1 then 0
        go(0, 2'b11, 0, 0, 0);
        go(0, 2'b11, 0, 0, 0);
        go(0, 2'b00, 0, 0, 0);
        go(0, 2'b00, 0, 0, 1);
        go(0, 2'b00, 0, 0, 0);
        go(0, 2'b00, 0, 0, 0);
        chk("t4_action0", pipe_action_mm5, 2'b10);
        go(0, 2'b00, 0, 0, 0);
        chk("t4_action1", pipe_action_mm5, 2'b01);

        // arbitration block holds the pointer
        go(0, 2'b01, 1, 0, 0);
        chk("t5_blk_gnt0", gnt_mm0, 2'b00);
        go(0, 2'b01, 1, 0, 0);
        chk("t5_blk_gnt1", gnt_mm0, 2'b00);
        go(0, 2'b01, 0, 0, 0);
        chk("t5_gnt", gnt_mm0, 2'b01);
        go(0, 2'b11, 0, 0, 0);
        chk("t5_ptr_gnt", gnt_mm0, 2'b10);

        // ops in mm1, mm3, mm5 then nuke
        go(0, 2'b00, 0, 0, 0);
        go(0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 5; i++) go(0, (i % 2 == 0) ? 2'b01 : 2'b00, 0, 0, 1);
        go(0, 2'b01, 0, 1, 1);
        chk("t6_pipe_valid", pipe_valid_mm5, 1'b0);
        chk("t6_gnt", gnt_mm0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            go(0, 2'b00, 0, 0, 1);
            chk("t6_post_pipe", pipe_valid_mm5, 1'b0);
            chk("t6_post_lookup", lookup_valid_mm2, 1'b0);
        end

        // reset mid-stream
        for (int i = 0; i < 5; i++) go(0, 2'b11, 0, 0, 1);
        @(posedge clk);
        #1;
        cyc++;
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t1_pipe_valid", pipe_valid_mm5, 1'b0);
        chk("t1_lookup_valid", lookup_valid_mm2, 1'b0);
        chk("t1_gnt", gnt_mm0, 2'b00);
        go(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            go(0, 2'b00, 0, 0, 1);
            chk("t1_post_pipe", pipe_valid_mm5, 1'b0);
        end

        // randomized traffic
        for (int i = 0; i < 1000; i++)
            go($urandom_range(99) < 2, 2'($urandom), $urandom_range(99) < 15,
               $urandom_range(99) < 8, 1'($urandom));
        go(0, 2'b00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
